// File: rtl/c2c_arbiter.sv
// Two-requester round-robin arbiter for a shared c2c_data memory bus.
// Grants are registered; the slave-side mux and ack routing follow the grant combinationally.
module c2c_arbiter #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  // requester 0 (instruction fetch)
  input  logic [XLEN-1:0] m0_addr,
  input  logic [XLEN-1:0] m0_data_w,
  input  logic [3:0]      m0_sel,
  input  logic            m0_re,
  input  logic            m0_we,
  output logic            m0_ack,
  output logic [XLEN-1:0] m0_data_r,
  // requester 1 (load/store unit)
  input  logic [XLEN-1:0] m1_addr,
  input  logic [XLEN-1:0] m1_data_w,
  input  logic [3:0]      m1_sel,
  input  logic            m1_re,
  input  logic            m1_we,
  output logic            m1_ack,
  output logic [XLEN-1:0] m1_data_r,
  // shared memory-side bus
  output logic [XLEN-1:0] s_addr,
  output logic [XLEN-1:0] s_data_w,
  output logic [3:0]      s_sel,
  output logic            s_re,
  output logic            s_we,
  input  logic            s_ack,
  input  logic [XLEN-1:0] s_data_r,
  // status
  output logic            bus_err,
  output logic [1:0]      grant
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  // The counter equals the number of completed wait cycles, so the last
  // permitted grant cycle is the one where it reads TIMEOUT-1.
  localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT - 1);

  state_t      state;
  logic        last_m1;
  logic [15:0] wait_cnt;

  logic pend0;
  logic pend1;
  logic own_pend;
  logic timed_out;

  assign pend0     = m0_re | m0_we;
  assign pend1     = m1_re | m1_we;
  assign timed_out = (wait_cnt == LAST_WAIT);

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    own_pend = 1'b0;
    s_addr   = '0;
    s_data_w = '0;
    s_sel    = '0;
    s_re     = 1'b0;
    s_we     = 1'b0;
    m0_ack   = 1'b0;
    m1_ack   = 1'b0;
    case (state)
      GNT0: begin
        own_pend = pend0;
        s_addr   = m0_addr;
        s_data_w = m0_data_w;
        s_sel    = m0_sel;
        s_re     = m0_re;
        s_we     = m0_we;
        m0_ack   = s_ack;
      end
      GNT1: begin
        own_pend = pend1;
        s_addr   = m1_addr;
        s_data_w = m1_data_w;
        s_sel    = m1_sel;
        s_re     = m1_re;
        s_we     = m1_we;
        m1_ack   = s_ack;
      end
      default: ;
    endcase
  end

  assign m0_data_r = s_data_r;
  assign m1_data_r = s_data_r;

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= 2'b00;
      last_m1  <= 1'b1;
      wait_cnt <= '0;
      bus_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          // On a tie the requester not served most recently wins.
          if (pend0 && (!pend1 || last_m1)) begin
            state <= GNT0;
            grant <= 2'b01;
          end else if (pend1) begin
            state <= GNT1;
            grant <= 2'b10;
          end
        end
        GNT0, GNT1: begin
          if (s_ack || !own_pend || timed_out) begin
            state   <= IDLE;
            grant   <= 2'b00;
            last_m1 <= (state == GNT1);
            // Ack wins over a coincident timeout; an abort is not an error.
            if (!s_ack && own_pend) begin
              bus_err <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_c2c_arbiter.sv
// Self-checking bench for c2c_arbiter: randomized masters and slave, transaction
// scoreboard, and a monitor that predicts grants from the round-robin rules.
module tb_c2c_arbiter;

  localparam int XLEN    = 32;
  localparam int TIMEOUT = 4;

  typedef struct {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic [3:0]      sel;
    logic            we;
  } item_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [XLEN-1:0] m0_addr = '0, m0_data_w = '0, m0_data_r;
  logic [3:0]      m0_sel = '0;
  logic            m0_re = 1'b0, m0_we = 1'b0, m0_ack;
  logic [XLEN-1:0] m1_addr = '0, m1_data_w = '0, m1_data_r;
  logic [3:0]      m1_sel = '0;
  logic            m1_re = 1'b0, m1_we = 1'b0, m1_ack;
  logic [XLEN-1:0] s_addr, s_data_w;
  logic [XLEN-1:0] s_data_r = '0;
  logic [3:0]      s_sel;
  logic            s_re, s_we;
  logic            s_ack = 1'b0;
  logic            bus_err;
  logic [1:0]      grant;

  int vectors     = 0;
  int miscompares = 0;

  item_t q0[$];
  item_t q1[$];

  // Slave behaviour: 0 random ack delay with idle ack noise, 1 never ack, 2 fixed delay.
  int  slave_mode = 0;
  int  fix_dly    = 0;
  bit  force_dr   = 1'b0;

  c2c_arbiter #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .m0_addr(m0_addr), .m0_data_w(m0_data_w), .m0_sel(m0_sel), .m0_re(m0_re),
    .m0_we(m0_we), .m0_ack(m0_ack), .m0_data_r(m0_data_r),
    .m1_addr(m1_addr), .m1_data_w(m1_data_w), .m1_sel(m1_sel), .m1_re(m1_re),
    .m1_we(m1_we), .m1_ack(m1_ack), .m1_data_r(m1_data_r),
    .s_addr(s_addr), .s_data_w(s_data_w), .s_sel(s_sel), .s_re(s_re), .s_we(s_we),
    .s_ack(s_ack), .s_data_r(s_data_r),
    .bus_err(bus_err), .grant(grant)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Slave model: counts cycles into each grant and acks after the chosen delay.
  initial begin : slave
    logic [1:0] sl_prev = 2'b00;
    int sl_cnt = 0;
    int sl_dly = 0;
    forever begin
      @(posedge clk);
      #1;
      s_data_r = force_dr ? 32'h0000_0080 : $urandom;
      if (grant != 2'b00) begin
        if (sl_prev == 2'b00) begin
          sl_cnt = 0;
          sl_dly = (slave_mode == 2) ? fix_dly : $urandom_range(0, 3);
        end
        s_ack = (slave_mode != 1) && (sl_cnt == sl_dly);
        sl_cnt++;
      end else begin
        s_ack = (slave_mode == 0) && ($urandom_range(0, 7) == 0);
      end
      sl_prev = grant;
    end
  end

  // Monitor: predicts the grant from the arbitration rules and scores completed transfers.
  logic [1:0] prev_grant = 2'b00, exp_g, g;
  logic       prev_p0 = 1'b0, prev_p1 = 1'b0, prev_end = 1'b0;
  logic       exp_err = 1'b0, last_m1 = 1'b1, cur_end, own_pend, have;
  int         gcycles = 0;
  item_t      it;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_grant", grant, 2'b00);
      check("rst_s_re", s_re, 1'b0);
      check("rst_s_we", s_we, 1'b0);
      check("rst_m0_ack", m0_ack, 1'b0);
      check("rst_m1_ack", m1_ack, 1'b0);
      check("rst_bus_err", bus_err, 1'b0);
      exp_err    = 1'b0;
      last_m1    = 1'b1;
      prev_grant = 2'b00;
      prev_end   = 1'b0;
      gcycles    = 0;
      prev_p0    = m0_re | m0_we;
      prev_p1    = m1_re | m1_we;
    end else begin
      if (prev_grant == 2'b00) begin
        if (prev_p0 && prev_p1) exp_g = last_m1 ? 2'b01 : 2'b10;
        else                    exp_g = {prev_p1, prev_p0};
      end else begin
        exp_g = prev_end ? 2'b00 : prev_grant;
      end
      check("grant", grant, exp_g);
      check("bus_err", bus_err, exp_err);
      check("m0_data_r", m0_data_r, s_data_r);
      check("m1_data_r", m1_data_r, s_data_r);
      cur_end = 1'b0;
      g = grant;
      if (g == 2'b01 || g == 2'b10) begin
        gcycles = (g != prev_grant) ? 1 : gcycles + 1;
        if (g == 2'b01) begin
          check("s_addr", s_addr, m0_addr);
          check("s_data_w", s_data_w, m0_data_w);
          check("s_sel", s_sel, m0_sel);
          check("s_re", s_re, m0_re);
          check("s_we", s_we, m0_we);
          check("m0_ack_route", m0_ack, s_ack);
          check("m1_ack_blocked", m1_ack, 1'b0);
          own_pend = m0_re | m0_we;
        end else begin
          check("s_addr", s_addr, m1_addr);
          check("s_data_w", s_data_w, m1_data_w);
          check("s_sel", s_sel, m1_sel);
          check("s_re", s_re, m1_re);
          check("s_we", s_we, m1_we);
          check("m1_ack_route", m1_ack, s_ack);
          check("m0_ack_blocked", m0_ack, 1'b0);
          own_pend = m1_re | m1_we;
        end
        have = (g == 2'b01) ? (q0.size() != 0) : (q1.size() != 0);
        if (s_ack) begin
          check("sb_outstanding", have, 1'b1);
          if (have) begin
            if (g == 2'b01) it = q0.pop_front();
            else            it = q1.pop_front();
            check("sb_addr", s_addr, it.addr);
            check("sb_data_w", s_data_w, it.data);
            check("sb_sel", s_sel, it.sel);
            check("sb_we", s_we, it.we);
            check("sb_re", s_re, !it.we);
          end
          cur_end = 1'b1;
        end else if (!own_pend) begin
          if (have) begin
            if (g == 2'b01) void'(q0.pop_front());
            else            void'(q1.pop_front());
          end
          cur_end = 1'b1;
        end else if (gcycles >= TIMEOUT) begin
          exp_err = 1'b1;
          cur_end = 1'b1;
        end
        if (cur_end) last_m1 = (g == 2'b10);
      end else begin
        check("idle_s_re", s_re, 1'b0);
        check("idle_s_we", s_we, 1'b0);
        check("idle_s_addr", s_addr, '0);
        check("idle_s_data_w", s_data_w, '0);
        check("idle_s_sel", s_sel, 4'h0);
        check("idle_m0_ack", m0_ack, 1'b0);
        check("idle_m1_ack", m1_ack, 1'b0);
        gcycles = 0;
      end
      prev_grant = g;
      prev_end   = cur_end;
      prev_p0    = m0_re | m0_we;
      prev_p1    = m1_re | m1_we;
    end
  end

  // Issue one transfer from master m, hold it until acked, then release the request.
  task automatic txn(input bit m, input bit we, input logic [XLEN-1:0] a,
                     input logic [XLEN-1:0] d, input logic [3:0] sel);
    item_t t;
    int    n;
    logic  seen;
    t = '{addr: a, data: d, sel: sel, we: we};
    if (m) begin
      m1_addr = a; m1_data_w = d; m1_sel = sel; m1_re = !we; m1_we = we;
      q1.push_back(t);
    end else begin
      m0_addr = a; m0_data_w = d; m0_sel = sel; m0_re = !we; m0_we = we;
      q0.push_back(t);
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
      seen = m ? m1_ack : m0_ack;
    end while (!seen && n < 200);
    check(m ? "m1_ack_seen" : "m0_ack_seen", seen, 1'b1);
    @(posedge clk);
    #1;
    if (m) begin m1_re = 1'b0; m1_we = 1'b0; end
    else   begin m0_re = 1'b0; m0_we = 1'b0; end
  endtask

  task automatic wait_grant(input logic [1:0] want);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (grant == want) break;
    end
    check("wait_grant", grant, want);
  endtask

  task automatic set_mode(input int mode);
    @(negedge clk);
    slave_mode = mode;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_grant", grant, 2'b00);
    check("async_rst_s_re", s_re, 1'b0);
    check("async_rst_s_we", s_we, 1'b0);
    check("async_rst_bus_err", bus_err, 1'b0);
    check("async_rst_m1_ack", m1_ack, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic rand_master(input bit m, input int n);
    for (int i = 0; i < n; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      txn(m, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom));
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1);
  end

  initial begin : main
    repeat (2) @(negedge clk);
    check("por_grant", grant, 2'b00);
    check("por_bus_err", bus_err, 1'b0);
    #1;
    rst = 1'b0;

    // Single read from m0, slave acks on the third grant cycle.
    slave_mode = 2;
    fix_dly    = 2;
    @(posedge clk);
    #1;
    txn(1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'hF);
    check("idle_after_ack", grant, 2'b00);

    // Tie straight out of reset: m0 first, then m1's write.
    pulse_reset();
    @(posedge clk);
    #1;
    fork
      txn(1'b0, 1'b0, 32'h0000_0104, 32'h0, 4'hF);
      txn(1'b1, 1'b1, 32'h0000_0204, 32'h1234_5678, 4'h3);
    join

    // Timeout on m1: bus_err sets, stays set, and m1 is re-arbitrated.
    set_mode(1);
    fork
      txn(1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'hF);
      begin
        for (int i = 0; i < 40 && !bus_err; i++) @(negedge clk);
        check("to_bus_err", bus_err, 1'b1);
        check("to_grant_idle", grant, 2'b00);
        @(negedge clk);
        check("to_regrant_m1", grant, 2'b10);
        repeat (8) @(negedge clk);
        check("to_sticky", bus_err, 1'b1);
        slave_mode = 0;
      end
    join

    // Abort: m0 drops its request mid-grant; pointer still moves to m0.
    set_mode(1);
    m0_addr = 32'h0000_0400; m0_data_w = 32'h0; m0_sel = 4'hF; m0_re = 1'b1; m0_we = 1'b0;
    q0.push_back('{addr: 32'h0000_0400, data: 32'h0, sel: 4'hF, we: 1'b0});
    wait_grant(2'b01);
    @(posedge clk);
    #1;
    m0_re = 1'b0;
    set_mode(0);
    fork
      txn(1'b0, 1'b1, 32'h0000_0500, 32'hAAAA_5555, 4'hC);
      txn(1'b1, 1'b0, 32'h0000_0600, 32'h0, 4'hF);
      begin
        repeat (2) @(negedge clk);
        check("abort_rr_m1", grant, 2'b10);
      end
    join

    // Read data broadcast to the non-granted master without an ack.
    @(negedge clk);
    slave_mode = 2;
    fix_dly    = 3;
    @(posedge clk);
    #1;
    fork
      txn(1'b0, 1'b0, 32'h0000_0700, 32'h0, 4'hF);
      begin
        wait_grant(2'b01);
        force_dr = 1'b1;
        @(posedge clk);
        #1;
        txn(1'b1, 1'b0, 32'h0000_0800, 32'h0, 4'h1);
      end
      begin
        wait_grant(2'b01);
        @(posedge clk);
        @(negedge clk);
        check("bcast_m1_data_r", m1_data_r, 32'h0000_0080);
        check("bcast_m1_ack", m1_ack, 1'b0);
        check("bcast_grant_held", grant, 2'b01);
        force_dr = 1'b0;
      end
    join

    // Reset during a GNT1 write; m0 wins the tie after release.
    set_mode(1);
    fork
      txn(1'b1, 1'b1, 32'h0000_0900, 32'hCAFE_0001, 4'hF);
      begin
        @(posedge clk);
        #1;
        txn(1'b0, 1'b0, 32'h0000_0A00, 32'h0, 4'hF);
      end
      begin
        wait_grant(2'b10);
        pulse_reset();
        slave_mode = 0;
        @(negedge clk);
        check("post_rst_m0_wins", grant, 2'b01);
      end
    join

    // Both held pending across four transfers: strict alternation.
    fork
      begin
        txn(1'b0, 1'b0, 32'h0000_0B00, 32'h0, 4'hF);
        txn(1'b0, 1'b1, 32'h0000_0B04, 32'h0BAD_F00D, 4'hF);
      end
      begin
        txn(1'b1, 1'b1, 32'h0000_0C00, 32'h0000_00C0, 4'h8);
        txn(1'b1, 1'b0, 32'h0000_0C04, 32'h0, 4'hF);
      end
    join

    // Random traffic from both masters.
    fork
      rand_master(1'b0, 40);
      rand_master(1'b1, 40);
    join

    repeat (4) @(negedge clk);
    check("sb_drain", q0.size() + q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/c2c_arbiter.md
C2C_ARBITER -- requirements
Module: c2c_arbiter

Interface
REQ-001 Parameter: XLEN, 32, data/address width of every c2c_data port.
REQ-002 Parameter: TIMEOUT, 255, max cycles a grant waits for slave ack; legal range 2..65535.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: m0  c2c_data.slave  XLEN addr/data, 4 sel  requester 0 (instruction fetch).
REQ-006 Port: m1  c2c_data.slave  XLEN addr/data, 4 sel  requester 1 (load/store unit).
REQ-007 Port: s  c2c_data.master  XLEN addr/data, 4 sel  shared memory-side bus.
REQ-008 Port: bus_err  output  1  sticky flag, set on any grant timeout.
REQ-009 Port: grant  output  2  one-hot current owner ({m1,m0}); 2'b00 when idle.

Function
REQ-010 A requester SHALL be pending while its re or we is high; masters hold addr/data_w/sel/re/we stable until ack.
REQ-011 FSM states SHALL be IDLE, GNT0, GNT1.
REQ-012 IDLE: no pending -> stay IDLE; exactly one pending -> GNTx for that requester next cycle.
REQ-013 IDLE with both pending SHALL grant the requester not granted most recently (round-robin); the last-grant pointer resets to m1, so m0 wins the first tie.
REQ-014 Grant latency: request first high in cycle N while IDLE -> grant visible and slave driven in cycle N+1.
REQ-015 In GNTx, s.addr, s.data_w, s.sel, s.re, s.we SHALL combinationally equal mx's fields.
REQ-016 In IDLE, s.re and s.we SHALL be 0; s.addr, s.data_w, s.sel SHALL be 0.
REQ-017 s.ack SHALL route combinationally only to the granted master; non-granted master ack SHALL be 0 always.
REQ-018 s.data_r SHALL broadcast to both masters' data_r unchanged.
REQ-019 In GNTx, s.ack=1 -> IDLE next cycle; last-grant pointer updated to x on that edge.
REQ-020 After an ack, at least one IDLE cycle SHALL separate consecutive grants (ack in N, next grant earliest N+2).
REQ-021 In GNTx, granted master dropping both re and we before ack SHALL abort: IDLE next cycle, pointer still updated to x.
REQ-022 A wait counter SHALL clear on entry to GNTx and increment each GNTx cycle without ack.
REQ-023 Counter reaching TIMEOUT without ack SHALL force IDLE next cycle, set bus_err, update pointer to x; no ack is sent to the master.
REQ-024 A timed-out master still pending SHALL be re-arbitrated normally from IDLE.
REQ-025 s.ack in IDLE SHALL be ignored (no master sees it, no state change).
REQ-026 bus_err SHALL stay 1 until reset; multiple timeouts have no further effect.
REQ-027 Simultaneous ack and timeout in the same cycle SHALL be treated as ack; bus_err unchanged.
REQ-028 Request changes on the non-granted master SHALL not affect the current grant.

Reset
REQ-029 rst high SHALL force IDLE immediately, grant=2'b00, s.re=s.we=0, both master acks 0, bus_err=0, counter=0, pointer=m1.
REQ-030 Reset asserted mid-grant SHALL drop s.re/s.we in the same cycle; no ack delivered for the aborted transfer.
REQ-031 First arbitration SHALL occur on the first rising edge with rst low.

Verification
REQ-032 m0.re=1 addr=0x100 alone, slave acks 2 cycles after grant -> grant=01 cycle N+1, m0.ack one cycle, IDLE after, m1.ack=0 throughout.
REQ-033 m0.re and m1.we high together from reset -> m0 granted first; after ack, one IDLE cycle, then m1 granted with s.we=1 and s.addr=m1.addr.
REQ-034 Both held pending across four transfers -> grant order m0,m1,m0,m1.
REQ-035 TIMEOUT=4, slave never acks m1 -> IDLE after 4 grant cycles, bus_err=1 and sticky, m1 re-granted next arbitration.
REQ-036 rst asserted during GNT1 with m1.we=1 -> s.we=0 same cycle, grant=00, bus_err=0, after release m0 wins a tie.
REQ-037 m1.re=1 with 0x80 on s.data_r while m0 granted -> m1.data_r=0x80 but m1.ack=0.
